lo_psync_seq: RTL and testbench

- Sequencer directly downstream of the LO div2 phase-sync controller. It consumes the controller's DONE and EXCHOP and drives its EN and its asynchronous reset.
- Runs one or more sync attempts per START. Each attempt resets the controller, arms it, waits for completion, and retries on failure or timeout.
- Holds the final I/Q swap decision for the LO output mux and reports status to the register bank.

---
 rtl/lo_psync_pkg.sv | 50 +++++
 rtl/lo_psync_tmr.sv | 54 +++++
 rtl/lo_psync_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_lo_psync_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lo_psync_pkg.sv
// ----------------------------------------------------------------------------
// lo_psync_pkg
//
// Purpose:
//   Shared definitions for the LO div2 phase-sync sequencer slice: the
//   sequencer state encoding, the encodings of the controller DONE field and
//   of the STATUS word, and small decode helpers used by the sequencer.
//
// Contents:
//   state_e       - sequencer states (3 bits)
//   DONE_*        - PS_DONE encodings ([1] finished, [0] success)
//   STATUS_*      - STATUS encodings ([1] sequence finished, [0] success)
//   state_busy    - 1 for every state except IDLE, OK and FAIL
//   state_status  - STATUS value presented while in a given state
// ----------------------------------------------------------------------------
package lo_psync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ARM    = 3'd3,
        ST_RETRY  = 3'd4,
        ST_OK     = 3'd5,
        ST_FAIL   = 3'd6
    } state_e;

    localparam logic [1:0] DONE_RUN  = 2'b00;
    localparam logic [1:0] DONE_FAIL = 2'b10;
    localparam logic [1:0] DONE_OK   = 2'b11;

    localparam logic [1:0] STATUS_NONE = 2'b00;
    localparam logic [1:0] STATUS_FAIL = 2'b10;
    localparam logic [1:0] STATUS_OK   = 2'b11;

    function automatic logic state_busy(input state_e s);
        return !((s == ST_IDLE) || (s == ST_OK) || (s == ST_FAIL));
    endfunction

    function automatic logic [1:0] state_status(input state_e s);
        logic [1:0] st;
        case (s)
            ST_OK:   st = STATUS_OK;
            ST_FAIL: st = STATUS_FAIL;
            default: st = STATUS_NONE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/lo_psync_tmr.sv
// ----------------------------------------------------------------------------
// lo_psync_tmr
//
// Purpose:
//   Cycle counter shared by the reset/settle dwell and the ARM timeout of the
//   phase-sync sequencer. The counter clears to zero, counts up while enabled
//   and saturates at all-ones instead of wrapping. The terminal value is
//   loaded combinationally by the owner each cycle; HIT flags that the
//   current count equals it.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear (wins over en)
//   en     in   count enable
//   term   in   W  terminal value compared against the count
//   hit    out  count equals term
// ----------------------------------------------------------------------------
module lo_psync_tmr #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         hit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturating up-count: once at all-ones the count sticks so a disabled
    // timeout (very long ARM) can never alias back onto a small terminal.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == term);

endmodule

// File: rtl/lo_psync_seq.sv
// ----------------------------------------------------------------------------
// lo_psync_seq
//
// Purpose:
//   Sequencer sitting directly downstream of the LO div2 phase-sync
//   controller. Each START runs up to MAX_RETRY+1 sync attempts. An attempt
//   holds the controller in reset for RST_CYC cycles, lets it settle for
//   another RST_CYC cycles, then enables it and waits for DONE or a timeout.
//   A failed or timed-out attempt is retried until the attempt budget is
//   spent. The final I/Q swap decision is held for the LO output mux and a
//   status summary is presented to the register bank.
//
// Optional feature (macro LO_PSYNC_SEQ_IRQ_EN):
//   Adds IRQ, a one-cycle pulse on entry to OK or FAIL, and IRQ_MASK which
//   suppresses that pulse. Without the macro neither port exists.
//
// Ports:
//   CLK        in   clock, rising edge
//   NARST      in   asynchronous active-low reset
//   START      in   one-cycle pulse, begins a sequence (ignored while BUSY)
//   ABORT      in   level, forces IDLE; highest priority
//   TIMEOUT    in   TOW  ARM cycles allowed per attempt, 0 disables
//   PS_DONE    in   2    controller DONE: [1] finished, [0] success
//   PS_EXCHOP  in   controller I/Q exchange request
//   IRQ_MASK   in   (IRQ build only) suppress the IRQ pulse
//   IRQ        out  (IRQ build only) pulse on entry to OK / FAIL
//   PS_EN      out  controller enable
//   PS_NARST   out  controller reset, active low, registered
//   IQ_SWAP    out  I/Q exchange applied at the LO mux
//   BUSY       out  high in every state except IDLE, OK, FAIL
//   STATUS     out  2    [1] sequence finished, [0] success
//   TO_FLAG    out  last attempt ended by timeout
//   ATTEMPTS   out  AW   attempts started in the current or last sequence
// ----------------------------------------------------------------------------
module lo_psync_seq
    import lo_psync_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int RST_CYC   = 8,
    parameter int TOW       = 20,
    parameter int AW        = 3
) (
    input  logic           CLK,
    input  logic           NARST,
    input  logic           START,
    input  logic           ABORT,
    input  logic [TOW-1:0] TIMEOUT,
    input  logic [1:0]     PS_DONE,
    input  logic           PS_EXCHOP,
`ifdef LO_PSYNC_SEQ_IRQ_EN
    input  logic           IRQ_MASK,
    output logic           IRQ,
`endif
    output logic           PS_EN,
    output logic           PS_NARST,
    output logic           IQ_SWAP,
    output logic           BUSY,
    output logic [1:0]     STATUS,
    output logic           TO_FLAG,
    output logic [AW-1:0]  ATTEMPTS
);

    localparam logic [TOW-1:0] DWELL_TERM   = TOW'(RST_CYC - 1);
    localparam logic [AW-1:0]  LAST_ATTEMPT = AW'(MAX_RETRY + 1);

    state_e          state_q;
    state_e          state_d;
    logic            ps_en_q;
    logic            ps_en_d;
    logic            ps_narst_q;
    logic            ps_narst_d;
    logic            iq_swap_q;
    logic            iq_swap_d;
    logic            busy_q;
    logic            busy_d;
    logic [1:0]      status_q;
    logic [1:0]      status_d;
    logic            to_flag_q;
    logic            to_flag_d;
    logic [AW-1:0]   attempts_q;
    logic [AW-1:0]   attempts_d;
`ifdef LO_PSYNC_SEQ_IRQ_EN
    logic            irq_q;
    logic            irq_d;
`endif

    logic            tmr_clr;
    logic            tmr_en;
    logic            tmr_hit;
    logic [TOW-1:0]  tmr_term;
    logic            arm_timeout;

    // One counter serves both dwells and the ARM timeout. It restarts at
    // zero on every state change, so in RST/SETTLE it hits after exactly
    // RST_CYC cycles and in ARM after exactly TIMEOUT cycles.
    always_comb begin
        tmr_term = DWELL_TERM;
        if (state_q == ST_ARM) begin
            tmr_term = TIMEOUT - TOW'(1);
        end
    end

    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = (state_q == ST_RST) || (state_q == ST_SETTLE) ||
                     (state_q == ST_ARM);

    lo_psync_tmr #(
        .W (TOW)
    ) u_tmr (
        .clk   (CLK),
        .rst_n (NARST),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .term  (tmr_term),
        .hit   (tmr_hit)
    );

    // A finished controller always wins over an expiring timeout, so the
    // timeout only qualifies while DONE[1] is still low.
    assign arm_timeout = (TIMEOUT != '0) && tmr_hit && !PS_DONE[1];

    // Next-state and bookkeeping. ABORT overrides everything, including a
    // START in the same cycle, and leaves ATTEMPTS/TO_FLAG untouched so the
    // aborted sequence can still be inspected.
    always_comb begin
        state_d    = state_q;
        to_flag_d  = to_flag_q;
        attempts_d = attempts_q;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_OK, ST_FAIL: begin
                    if (START) begin
                        state_d    = ST_RST;
                        attempts_d = AW'(1);
                        to_flag_d  = 1'b0;
                    end
                end
                ST_RST: begin
                    if (tmr_hit) begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_hit) begin
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (PS_DONE == DONE_OK) begin
                        state_d = ST_OK;
                    end else if (PS_DONE == DONE_FAIL) begin
                        state_d = ST_RETRY;
                    end else if (arm_timeout) begin
                        state_d   = ST_RETRY;
                        to_flag_d = 1'b1;
                    end
                end
                ST_RETRY: begin
                    if (attempts_q == LAST_ATTEMPT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d    = ST_RST;
                        attempts_d = attempts_q + AW'(1);
                        to_flag_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so each one is
    // a flop that tracks the state register with no decode glitches; this
    // matters most for PS_NARST, which is an asynchronous reset downstream.
    // IQ_SWAP follows PS_EXCHOP one cycle late while in ARM, is held through
    // OK, and is forced low everywhere else.
    always_comb begin
        ps_en_d    = (state_d == ST_ARM) || (state_d == ST_OK);
        ps_narst_d = (state_d != ST_RST);
        busy_d     = state_busy(state_d);
        status_d   = state_status(state_d);
        iq_swap_d  = 1'b0;
        if ((state_d == ST_ARM) || (state_d == ST_OK)) begin
            iq_swap_d = (state_q == ST_ARM) ? PS_EXCHOP : iq_swap_q;
        end
    end

`ifdef LO_PSYNC_SEQ_IRQ_EN
    always_comb begin
        irq_d = (state_d != state_q) &&
                ((state_d == ST_OK) || (state_d == ST_FAIL)) &&
                !IRQ_MASK;
    end
`endif

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            state_q    <= ST_IDLE;
            ps_en_q    <= 1'b0;
            ps_narst_q <= 1'b1;
            iq_swap_q  <= 1'b0;
            busy_q     <= 1'b0;
            status_q   <= STATUS_NONE;
            to_flag_q  <= 1'b0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            ps_en_q    <= ps_en_d;
            ps_narst_q <= ps_narst_d;
            iq_swap_q  <= iq_swap_d;
            busy_q     <= busy_d;
            status_q   <= status_d;
            to_flag_q  <= to_flag_d;
            attempts_q <= attempts_d;
        end
    end

`ifdef LO_PSYNC_SEQ_IRQ_EN
    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign IRQ = irq_q;
`endif

    assign PS_EN    = ps_en_q;
    assign PS_NARST = ps_narst_q;
    assign IQ_SWAP  = iq_swap_q;
    assign BUSY     = busy_q;
    assign STATUS   = status_q;
    assign TO_FLAG  = to_flag_q;
    assign ATTEMPTS = attempts_q;

endmodule

// File: tb/tb_lo_psync_seq.sv
// ----------------------------------------------------------------------------
// tb_lo_psync_seq
//
// Bench for lo_psync_seq. A behavioural phase-sync controller model answers
// PS_EN/PS_NARST with a programmable latency, a number of failing attempts
// before success, or never. Each table vector pushes its expected outcome to
// a scoreboard queue when START is driven; the entry is popped and compared
// once the sequencer drops BUSY. Hand-written sequences cover ABORT, reset
// mid-sequence and (with LO_PSYNC_SEQ_IRQ_EN) the IRQ mask.
// ----------------------------------------------------------------------------
module tb_lo_psync_seq;

    localparam int TOW = 20;
    localparam int AW  = 3;

    logic           CLK       = 1'b0;
    logic           NARST     = 1'b0;
    logic           START     = 1'b0;
    logic           ABORT     = 1'b0;
    logic [TOW-1:0] TIMEOUT   = '0;
    logic [1:0]     PS_DONE   = 2'b00;
    logic           PS_EXCHOP = 1'b0;
    logic           PS_EN;
    logic           PS_NARST;
    logic           IQ_SWAP;
    logic           BUSY;
    logic [1:0]     STATUS;
    logic           TO_FLAG;
    logic [AW-1:0]  ATTEMPTS;
`ifdef LO_PSYNC_SEQ_IRQ_EN
    logic           IRQ;
    logic           IRQ_MASK = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    lo_psync_seq #(
        .MAX_RETRY (3),
        .RST_CYC   (8),
        .TOW       (TOW),
        .AW        (AW)
    ) dut (
        .CLK       (CLK),
        .NARST     (NARST),
        .START     (START),
        .ABORT     (ABORT),
        .TIMEOUT   (TIMEOUT),
        .PS_DONE   (PS_DONE),
        .PS_EXCHOP (PS_EXCHOP),
`ifdef LO_PSYNC_SEQ_IRQ_EN
        .IRQ_MASK  (IRQ_MASK),
        .IRQ       (IRQ),
`endif
        .PS_EN     (PS_EN),
        .PS_NARST  (PS_NARST),
        .IQ_SWAP   (IQ_SWAP),
        .BUSY      (BUSY),
        .STATUS    (STATUS),
        .TO_FLAG   (TO_FLAG),
        .ATTEMPTS  (ATTEMPTS)
    );

    always #5 CLK = ~CLK;

    // Controller model: reset while PS_NARST is low, counts enabled cycles,
    // reports DONE=10 for the first m_fails attempts and DONE=11 afterwards.
    int m_lat     = 1;
    int m_fails   = 0;
    bit m_hang    = 1'b0;
    int m_cnt     = 0;
    int m_attempt = 0;
    bit m_in_rst  = 1'b0;

    always @(negedge CLK) begin
        if (!BUSY) m_attempt = 0;
        if (!PS_NARST) begin
            if (!m_in_rst) m_attempt++;
            m_in_rst = 1'b1;
            m_cnt    = 0;
            PS_DONE  = 2'b00;
        end else begin
            m_in_rst = 1'b0;
            if (PS_EN && (PS_DONE == 2'b00) && !m_hang) begin
                m_cnt++;
                if (m_cnt == m_lat) PS_DONE = (m_attempt <= m_fails) ? 2'b10 : 2'b11;
            end
        end
    end

    // Monitor sampled 1 time unit after each rising edge.
    bit mon_on     = 1'b0;
    bit prev_narst = 1'b1;
    int cyc        = 0;
    int low_cnt    = 0;
    int falls      = 0;
    int arm_cyc    = 0;
    int first_en   = 0;
    int irq_cnt    = 0;

    always @(posedge CLK) begin
        #1;
        if (mon_on) begin
            cyc++;
            if (!PS_NARST) low_cnt++;
            if (prev_narst && !PS_NARST) falls++;
            prev_narst = PS_NARST;
            if (PS_EN && BUSY) arm_cyc++;
            if (PS_EN && (first_en == 0)) first_en = cyc;
`ifdef LO_PSYNC_SEQ_IRQ_EN
            if (IRQ) irq_cnt++;
`endif
        end
    end

    typedef struct {
        int         lat;
        int         fails;
        bit         hang;
        int         tmo;
        bit         exchop;
        logic [1:0] status;
        int         attempts;
        bit         to_flag;
        bit         iq;
        bit         en;
        int         resets;
        int         arm_cycles;
    } vec_t;

    typedef struct {
        int status;
        int attempts;
        int to_flag;
        int iq;
        int en;
        int resets;
        int low_cycles;
        int arm_cycles;
        int first_en;
        int irq;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        exp_t e;
        int   n;
        m_lat     = v.lat;
        m_fails   = v.fails;
        m_hang    = v.hang;
        PS_EXCHOP = v.exchop;
        TIMEOUT   = TOW'(v.tmo);
        e.status     = int'(v.status);
        e.attempts   = v.attempts;
        e.to_flag    = int'(v.to_flag);
        e.iq         = int'(v.iq);
        e.en         = int'(v.en);
        e.resets     = v.resets;
        e.low_cycles = 8 * v.resets;
        e.arm_cycles = v.arm_cycles;
        e.first_en   = 17;
`ifdef LO_PSYNC_SEQ_IRQ_EN
        e.irq        = IRQ_MASK ? 0 : 1;
`else
        e.irq        = 0;
`endif
        @(negedge CLK);
        cyc = 0; low_cnt = 0; falls = 0; arm_cyc = 0; first_en = 0; irq_cnt = 0;
        prev_narst = 1'b1;
        mon_on = 1'b1;
        START = 1'b1;
        exp_q.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        chk({tag, "_start_attempts"}, 32'(ATTEMPTS), 1);
        chk({tag, "_start_status"}, 32'(STATUS), 0);
        chk({tag, "_start_to_flag"}, 32'(TO_FLAG), 0);
        chk({tag, "_start_busy"}, 32'(BUSY), 1);
        chk({tag, "_start_ps_narst"}, 32'(PS_NARST), 0);
        n = 0;
        while (BUSY && (n < 20000)) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_busy_drop"}, 32'(BUSY), 0);
        @(negedge CLK);
        mon_on = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_status"}, 32'(STATUS), e.status);
            chk({tag, "_attempts"}, 32'(ATTEMPTS), e.attempts);
            chk({tag, "_to_flag"}, 32'(TO_FLAG), e.to_flag);
            chk({tag, "_iq_swap"}, 32'(IQ_SWAP), e.iq);
            chk({tag, "_ps_en"}, 32'(PS_EN), e.en);
            chk({tag, "_resets"}, falls, e.resets);
            chk({tag, "_narst_low"}, low_cnt, e.low_cycles);
            chk({tag, "_arm_cycles"}, arm_cyc, e.arm_cycles);
            chk({tag, "_en_delay"}, first_en, e.first_en);
`ifdef LO_PSYNC_SEQ_IRQ_EN
            chk({tag, "_irq"}, irq_cnt, e.irq);
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        //            lat  fl hang tmo ex  status att to  iq  en  rst arm
        vecs[0] = '{3000, 0, 1'b0,   0, 1'b1, 2'b11, 1, 1'b0, 1'b1, 1'b1, 1, 3000};
        vecs[1] = '{  50, 2, 1'b0,   0, 1'b0, 2'b11, 3, 1'b0, 1'b0, 1'b1, 3,  150};
        vecs[2] = '{   1, 0, 1'b1, 100, 1'b1, 2'b10, 4, 1'b1, 1'b0, 1'b0, 4,  400};
        vecs[3] = '{  40, 0, 1'b0,  40, 1'b1, 2'b11, 1, 1'b0, 1'b1, 1'b1, 1,   40};
        vecs[4] = '{  41, 0, 1'b0,  40, 1'b1, 2'b10, 4, 1'b1, 1'b0, 1'b0, 4,  160};
        vecs[5] = '{  10, 4, 1'b0,   0, 1'b0, 2'b10, 4, 1'b0, 1'b0, 1'b0, 4,   40};
        vecs[6] = '{  10, 3, 1'b0,   0, 1'b1, 2'b11, 4, 1'b0, 1'b1, 1'b1, 4,   40};

        repeat (3) @(negedge CLK);
        chk("rst_ps_narst_in_reset", 32'(PS_NARST), 1);
        NARST = 1'b1;
        @(negedge CLK);
        chk("rst_ps_en", 32'(PS_EN), 0);
        chk("rst_ps_narst", 32'(PS_NARST), 1);
        chk("rst_iq_swap", 32'(IQ_SWAP), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_status", 32'(STATUS), 0);
        chk("rst_to_flag", 32'(TO_FLAG), 0);
        chk("rst_attempts", 32'(ATTEMPTS), 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("v%0d", i), vecs[i]);
            checkOutput($sformatf("v%0d", i));
        end

        // ABORT in ARM of attempt 2, with a START in the same cycle.
        m_lat = 20; m_fails = 1; m_hang = 1'b0; PS_EXCHOP = 1'b1; TIMEOUT = '0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (!((ATTEMPTS == AW'(2)) && PS_EN) && (n < 500)) begin
            @(negedge CLK);
            n++;
        end
        chk("abort_reach_arm2", 32'(n < 500), 1);
        repeat (2) @(negedge CLK);
        chk("abort_iq_before", 32'(IQ_SWAP), 1);
        ABORT = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        chk("abort_ps_en", 32'(PS_EN), 0);
        chk("abort_ps_narst", 32'(PS_NARST), 1);
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_status", 32'(STATUS), 0);
        chk("abort_attempts", 32'(ATTEMPTS), 2);
        chk("abort_iq_swap", 32'(IQ_SWAP), 0);
        chk("abort_to_flag", 32'(TO_FLAG), 0);
        ABORT = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        chk("abort_start_ignored", 32'(BUSY), 0);
        chk("abort_attempts_held", 32'(ATTEMPTS), 2);

        // Reset asserted during RST.
        m_hang = 1'b1;
        TIMEOUT = TOW'(100);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        chk("narst_pre_ps_narst", 32'(PS_NARST), 0);
        NARST = 1'b0;
        #1;
        chk("narst_ps_narst", 32'(PS_NARST), 1);
        chk("narst_busy", 32'(BUSY), 0);
        chk("narst_ps_en", 32'(PS_EN), 0);
        chk("narst_attempts", 32'(ATTEMPTS), 0);
        chk("narst_status", 32'(STATUS), 0);
        @(negedge CLK);
        NARST = 1'b1;
        @(negedge CLK);

`ifdef LO_PSYNC_SEQ_IRQ_EN
        IRQ_MASK = 1'b1;
        applyStimulus("mask", vecs[3]);
        checkOutput("mask");
        IRQ_MASK = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
